// File: rtl/qa_tx_if.sv
`default_nettype none
// ============================================================================
//  Module      : qa_tx_if
//  Description : Byte-in handshake and serial-line status bundle for qa_tx.
//                master = byte producer / line observer, slave = transmitter.
//  Revision    : 1.0 - initial release
// ============================================================================
interface qa_tx_if;
  logic [7:0] data_in;
  logic       valid;
  logic       ready;
  logic       out;
  logic       busy;
  logic       frame_done;

  modport master (
    output data_in,
    output valid,
    input  ready,
    input  out,
    input  busy,
    input  frame_done
  );

  modport slave (
    input  data_in,
    input  valid,
    output ready,
    output out,
    output busy,
    output frame_done
  );
endinterface
`default_nettype wire

// File: rtl/qa_tx.sv
`default_nettype none
// ============================================================================
//  Module      : qa_tx
//  Description : Serial frame transmitter. Each accepted byte is sent as the
//                0111110 marker followed by the byte LSB first, with a single
//                1 stuffed after any run of five payload 1s so the marker
//                pattern can only appear at the start of a frame.
//  Revision    : 1.0 - initial release
// ============================================================================
module qa_tx #(
  parameter int CLKS_PER_BIT = 1
) (
  input  logic     clk,
  input  logic     rst,
  qa_tx_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MARK  = 2'd1,
    DATA  = 2'd2,
    STUFF = 2'd3
  } state_t;

  // Marker is symmetric, so bit order within the constant does not matter.
  localparam logic [6:0] c_mark     = 7'b0111110;
  localparam logic [7:0] c_div_last = 8'(CLKS_PER_BIT - 1);

  state_t     r_state;
  logic [7:0] r_shift;
  logic [7:0] r_div;
  logic [2:0] r_cnt;
  logic [2:0] r_ones;
  logic       r_out;
  logic       r_busy;
  logic       r_done;
  logic       r_ready;

  logic       w_bit_end;
  logic       w_cur_bit;
  logic [2:0] w_ones_next;

  // Current bit period ends on this clock; run length after the payload bit now on the line.
  assign w_bit_end   = (r_div == c_div_last);
  assign w_cur_bit   = r_shift[r_cnt];
  assign w_ones_next = w_cur_bit ? (r_ones + 3'd1) : 3'd0;

  // Frame sequencer: all line and status outputs are registered here.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_shift <= 8'd0;
      r_div   <= 8'd0;
      r_cnt   <= 3'd0;
      r_ones  <= 3'd0;
      r_out   <= 1'b1;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_ready <= 1'b1;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          r_out   <= 1'b1;
          r_busy  <= 1'b0;
          r_ready <= 1'b1;
          r_div   <= 8'd0;
          r_cnt   <= 3'd0;
          r_ones  <= 3'd0;
          // ready is always high here, so valid alone completes the handshake
          if (bus.valid) begin
            r_shift <= bus.data_in;
            r_state <= MARK;
            r_out   <= c_mark[0];
            r_busy  <= 1'b1;
            r_ready <= 1'b0;
          end
        end

        MARK: begin
          if (!w_bit_end) begin
            r_div <= r_div + 8'd1;
          end else begin
            r_div <= 8'd0;
            if (r_cnt == 3'd6) begin
              r_state <= DATA;
              r_cnt   <= 3'd0;
              r_ones  <= 3'd0;
              r_out   <= r_shift[0];
            end else begin
              r_cnt <= r_cnt + 3'd1;
              r_out <= c_mark[r_cnt + 3'd1];
            end
          end
        end

        DATA: begin
          if (!w_bit_end) begin
            r_div <= r_div + 8'd1;
          end else begin
            r_div  <= 8'd0;
            r_ones <= w_ones_next;
            if (w_ones_next == 3'd5) begin
              // Fifth consecutive payload 1: break the run before it can mimic the marker
              r_state <= STUFF;
              r_out   <= 1'b1;
            end else if (r_cnt == 3'd7) begin
              r_state <= IDLE;
              r_out   <= 1'b1;
              r_busy  <= 1'b0;
              r_ready <= 1'b1;
              r_done  <= 1'b1;
            end else begin
              r_cnt <= r_cnt + 3'd1;
              r_out <= r_shift[r_cnt + 3'd1];
            end
          end
        end

        STUFF: begin
          if (!w_bit_end) begin
            r_div <= r_div + 8'd1;
          end else begin
            r_div  <= 8'd0;
            r_ones <= 3'd0;
            if (r_cnt == 3'd7) begin
              r_state <= IDLE;
              r_out   <= 1'b1;
              r_busy  <= 1'b0;
              r_ready <= 1'b1;
              r_done  <= 1'b1;
            end else begin
              r_state <= DATA;
              r_cnt   <= r_cnt + 3'd1;
              r_out   <= r_shift[r_cnt + 3'd1];
            end
          end
        end

        default: begin
          r_state <= IDLE;
          r_out   <= 1'b1;
          r_busy  <= 1'b0;
          r_ready <= 1'b1;
        end
      endcase
    end
  end

  assign bus.ready      = r_ready;
  assign bus.out        = r_out;
  assign bus.busy       = r_busy;
  assign bus.frame_done = r_done;

endmodule
`default_nettype wire
